ma_stage: RTL and testbench
===========================

# ma_stage

Memory-access pipeline stage: the receiving end of the EX→MA register interface. Decodes `cmd_ld_ma`/`cmd_st_ma`/`ldst_code_ma`, formats store data and byte enables, runs a request/acknowledge handshake with the data cache, and aligns and sign-extends load data. Raises `dc_stall` while an access is outstanding, and drives the MA→WB registers plus the two write-back forwarding values consumed by EX.

## Interface
Parameters:
- none; opcode and state encodings come from the shared include.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_ld_ma` in 1: load in MA.
- `cmd_st_ma` in 1: store in MA (already purge-qualified).
- `rd_adr_ma` in 5: destination register.
- `rd_data_ma` in 32: ALU result; the effective address for ld/st, otherwise the write-back value.
- `wbk_rd_reg_ma` in 1: write-back enable.
- `st_data_ma` in 32: store source data.
- `ldst_code_ma` in 3: funct3.
- `stall` in 1: global stall. Externally ORed with `dc_stall`.
- `rst_pipe` in 1: pipeline flush.
- `dc_req` out 1: cache request.
- `dc_we` out 1: 1 = write.
- `dc_adr` out 30: word address [31:2].
- `dc_be` out 4: byte enables.
- `dc_wdata` out 32: write data.
- `dc_ack` in 1: request done. Read data is valid in the same cycle.
- `dc_rdata` in 32: read word.
- `dc_stall` out 1: MA cannot complete this cycle.
- `ldst_misalign_ma` out 1: misaligned-access pulse to the exception logic.
- `rd_adr_wb` out 5: WB destination.
- `wbk_rd_reg_wb` out 1: WB enable.
- `wbk_data_wb` out 32: WB data; forwarding source for the "MA-hit" path.
- `wbk_data_wb2` out 32: `wbk_data_wb` delayed one cycle; forwarding source for the "WB-hit" path.

## Operation
- **Access definition:** `acc = (cmd_ld_ma | cmd_st_ma) & ~mis`.
- **Misalignment (`mis`):**
  - code[1:0] = 01 with adr[0] = 1.
  - code[1:0] = 10 with adr[1:0] ≠ 00.
  - On `mis`: no request is issued, `ldst_misalign_ma` = 1 combinationally, and `wbk_rd_reg_wb` loads 0.
- **Stores:**
  - SB (000): data = {4{b}}, be = 0001 << adr[1:0].
  - SH (001): data = {2{h}}, be = 0011 << {adr[1],1'b0}.
  - SW (010): data = word, be = 1111.
- **Loads:**
  - Select the byte/half of `dc_rdata` by adr[1:0].
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW passes through.
  - Codes 011/110/111 are treated as LW/SW.
  - `dc_be` = 1111 for every load.
- **FSM states:**
  - **IDLE:**
    - `dc_req` = `acc`.
    - If `acc & ~dc_ack`: go to WAIT.
    - If `acc & dc_ack`: stay in IDLE, zero-wait.
  - **WAIT:**
    - `dc_req` = 1 with address, data, be and we held stable.
    - On `dc_ack`: go to IDLE.
  - **DRAIN:**
    - Entered when `rst_pipe` is asserted in WAIT.
    - `dc_req` stays 1 until `dc_ack`, then go to IDLE.
    - Read data is discarded; a store still completes in the cache.
- **Stall:**
  - `dc_stall` = (IDLE & `acc` & ~`dc_ack`) | (WAIT & ~`dc_ack`) | DRAIN.
- **Write-back data:**
  - `wb_pre` = `cmd_ld_ma` ? aligned load : `rd_data_ma`.
- **WB register update priority** (applies to `rd_adr_wb`, `wbk_rd_reg_wb`, `wbk_data_wb`, `wbk_data_wb2`):
  1. `~rst_n` → all 0.
  2. `rst_pipe` → all 0.
  3. `~stall` → load.
  4. Otherwise hold.
- **Enable and data while loading:**
  - `wbk_rd_reg_wb` loads `wbk_rd_reg_ma & ~mis`.
  - `wbk_data_wb2` loads the old `wbk_data_wb`.
- **Request gating:** `rst_pipe` in IDLE suppresses `acc` that cycle, so no request is issued.

## Timing
- **Reset values:** state = IDLE; all outputs 0 (`dc_req`, `dc_we`, `dc_adr`, `dc_be`, `dc_wdata`, `dc_stall`, `ldst_misalign_ma`, WB registers). Combinational outputs are 0 because the state is IDLE and the EX→MA inputs are reset.
- **Request outputs:** `dc_*` are combinational from MA inputs in IDLE, and from captured registers in WAIT/DRAIN.
- **Capture rule:**
  - The request is captured on the IDLE→WAIT edge.
  - The EX→MA inputs are held by the global stall anyway, but WAIT uses the registered copy.
- **Latency:**
  - Zero-wait hit: write-back data is in `wbk_data_wb` 1 clock after the MA cycle.
  - N-cycle miss: `dc_stall` is high for N cycles; data appears in WB on the edge after the `dc_ack` cycle.
- **Handshake rules:**
  - Once `dc_req` is 1, it stays 1 until `dc_ack` is sampled.
  - `dc_ack` with `dc_req` = 0 is ignored.
- **Synchronous reset mid-WAIT:** state goes to IDLE and `dc_req` drops the next cycle. The cache is reset together with the core.
- **Simultaneous events:**
  - `rst_pipe` with `dc_ack` in WAIT: go to IDLE, not DRAIN.
  - `rst_pipe` in DRAIN: no effect.
- **Misaligned pulse:** `ldst_misalign_ma` lasts exactly as long as the offending instruction sits in MA. Normally that is 1 cycle, longer under an external `stall`.

## Structure
- **Shared include** (`ma_defs.vh`):
  - State encodings: IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2.
  - funct3 localparams: LB/LH/LW/LBU/LHU/SB/SH/SW.
- **Sub-module `ldst_align`** (purely combinational):
  - Store lane replication and byte-enable generation.
  - Misalignment detection.
  - Load extract and extend.
- **`ma_stage` itself:** the FSM, request capture registers and WB registers.

## Test plan
- SW, adr 0x100, data 0xDEADBEEF, ack in the same cycle → `dc_req` = 1, `dc_we` = 1, `dc_be` = 1111, `dc_adr` = 0x40, `dc_stall` = 0 throughout.
- SB, adr 0x103, data 0x000000A5 → `dc_be` = 1000, `dc_wdata` = 0xA5A5A5A5.
- LB, adr 0x102, `dc_rdata` 0x12F03456, ack after 3 cycles → `dc_stall` high for 3 cycles, request outputs held stable, `wbk_data_wb` = 0xFFFFFFF0. Repeat as LBU → 0x000000F0.
- LW, adr 0x101 → no `dc_req`, `ldst_misalign_ma` = 1 for one cycle, `wbk_rd_reg_wb` = 0.
- LH miss with `rst_pipe` pulsed in WAIT → DRAIN entered, `dc_req` held until ack, then IDLE; `wbk_rd_reg_wb` stays 0.
- ALU result 0x55 to x5, then the next instruction → `wbk_data_wb` = 0x55 one cycle after MA, `wbk_data_wb2` = 0x55 the cycle after; `rst_n` low mid-WAIT → IDLE with all outputs 0 next cycle.

Source files
------------

// File: rtl/ma_stage_pkg.sv
// Shared encodings for the memory-access stage: FSM states and funct3 codes.
package ma_stage_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_WAIT  = 2'd1,
    MA_DRAIN = 2'd2
  } ma_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/ma_stage_ldst_align.sv
// Combinational load/store formatting: store lane replication and byte
// enables, misalignment detection, and load byte/half extract with extension.
module ma_stage_ldst_align
  import ma_stage_pkg::*;
(
  input  logic [2:0]  code,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        mis
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; code 11 is not checked.
  always_comb begin
    mis = 1'b0;
    if (code[1:0] == F3_LH[1:0]) begin
      mis = adr_lo[0];
    end else if (code[1:0] == F3_LW[1:0]) begin
      mis = (adr_lo != 2'b00);
    end
  end

  // Store width follows code[1:0]; anything not byte/half is a full word.
  always_comb begin
    st_be    = BE_ALL;
    st_wdata = st_data;
    case ({1'b0, code[1:0]})
      F3_SB: begin
        st_be    = 4'b0001 << adr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_be    = 4'b0011 << {adr_lo[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      F3_SW: begin
        st_be    = BE_ALL;
        st_wdata = st_data;
      end
      default: begin
        st_be    = BE_ALL;
        st_wdata = st_data;
      end
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    case (adr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = adr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (code)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'd0, ld_byte};
      F3_LHU:  ld_data = {16'd0, ld_half};
      F3_LW:   ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: data-cache request/ack FSM, request capture registers
// and MA->WB registers with the two forwarding taps.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// MA_IDLE  | request driven from live MA inputs; zero-wait hits stay here
// MA_WAIT  | request outstanding, driven from captured copy, stalling
// MA_DRAIN | flushed while outstanding; hold request until ack, drop data
module ma_stage
  import ma_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic        dc_req,
  output logic        dc_we,
  output logic [29:0] dc_adr,
  output logic [3:0]  dc_be,
  output logic [31:0] dc_wdata,
  input  logic        dc_ack,
  input  logic [31:0] dc_rdata,
  output logic        dc_stall,
  output logic        ldst_misalign_ma,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [31:0] wbk_data_wb2
);

  ma_state_e   state_q, state_d;

  logic        ld_q, st_q;
  logic [31:0] adr_q, st_data_q;
  logic [2:0]  code_q;

  logic        use_cap;
  logic        is_ld, is_st;
  logic [31:0] adr_sel, st_data_sel;
  logic [2:0]  code_sel;

  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        mis_raw, mis_acc, acc, cap_en, stall_all;
  logic [31:0] wb_pre;

  // Outside IDLE the in-flight request comes from the captured copy, so a
  // flushed MA slot cannot disturb an access the cache is still serving.
  assign use_cap     = (state_q != MA_IDLE);
  assign is_ld       = use_cap ? ld_q      : cmd_ld_ma;
  assign is_st       = use_cap ? st_q      : cmd_st_ma;
  assign adr_sel     = use_cap ? adr_q     : rd_data_ma;
  assign code_sel    = use_cap ? code_q    : ldst_code_ma;
  assign st_data_sel = use_cap ? st_data_q : st_data_ma;

  ma_stage_ldst_align u_align (
    .code     (code_sel),
    .adr_lo   (adr_sel[1:0]),
    .st_data  (st_data_sel),
    .rdata    (dc_rdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_data  (ld_data),
    .mis      (mis_raw)
  );

  // ALU ops carry arbitrary funct3/result bits, so only ld/st can be misaligned.
  assign mis_acc = (is_ld | is_st) & mis_raw;
  assign acc     = (cmd_ld_ma | cmd_st_ma) & ~mis_acc & ~rst_pipe;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack always wins over a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MA_IDLE:  if (acc && !dc_ack) state_d = MA_WAIT;
      MA_WAIT: begin
        if (dc_ack)        state_d = MA_IDLE;
        else if (rst_pipe) state_d = MA_DRAIN;
      end
      MA_DRAIN: if (dc_ack) state_d = MA_IDLE;
      default:  state_d = MA_IDLE;
    endcase
  end

  // Request, stall and capture strobe per state.
  always_comb begin
    dc_req   = 1'b0;
    dc_stall = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      MA_IDLE: begin
        dc_req   = acc;
        dc_stall = acc & ~dc_ack;
        cap_en   = acc & ~dc_ack;
      end
      MA_WAIT: begin
        dc_req   = 1'b1;
        dc_stall = ~dc_ack;
      end
      MA_DRAIN: begin
        dc_req   = 1'b1;
        dc_stall = 1'b1;
      end
      default: begin
        dc_req   = 1'b0;
        dc_stall = 1'b0;
      end
    endcase
  end

  // Request payload is forced to zero whenever no request is presented.
  assign dc_we            = dc_req & is_st;
  assign dc_adr           = dc_req ? adr_sel[31:2] : 30'd0;
  assign dc_be            = !dc_req ? 4'd0 : (is_ld ? BE_ALL : st_be);
  assign dc_wdata         = (dc_req && is_st) ? st_wdata : 32'd0;
  assign ldst_misalign_ma = mis_acc;

  assign stall_all = stall | dc_stall;
  assign wb_pre    = is_ld ? ld_data : rd_data_ma;

  // Capture the request when it goes outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      adr_q     <= 32'd0;
      code_q    <= 3'd0;
      st_data_q <= 32'd0;
    end else if (cap_en) begin
      ld_q      <= cmd_ld_ma;
      st_q      <= cmd_st_ma;
      adr_q     <= rd_data_ma;
      code_q    <= ldst_code_ma;
      st_data_q <= st_data_ma;
    end
  end

  // MA->WB registers: reset, then flush, then advance when not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_adr_wb     <= 5'd0;
      wbk_rd_reg_wb <= 1'b0;
      wbk_data_wb   <= 32'd0;
      wbk_data_wb2  <= 32'd0;
    end else if (rst_pipe) begin
      rd_adr_wb     <= 5'd0;
      wbk_rd_reg_wb <= 1'b0;
      wbk_data_wb   <= 32'd0;
      wbk_data_wb2  <= 32'd0;
    end else if (!stall_all) begin
      rd_adr_wb     <= rd_adr_ma;
      wbk_rd_reg_wb <= wbk_rd_reg_ma & ~mis_acc;
      wbk_data_wb   <= wb_pre;
      wbk_data_wb2  <= wbk_data_wb;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: directed scenarios plus a randomized run
// against an arithmetic reference model of the load/store formatting rules.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_ma, cmd_st_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma;
  logic        wbk_rd_reg_ma;
  logic [31:0] st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        stall, rst_pipe;
  logic        dc_req, dc_we;
  logic [29:0] dc_adr;
  logic [3:0]  dc_be;
  logic [31:0] dc_wdata;
  logic        dc_ack;
  logic [31:0] dc_rdata;
  logic        dc_stall, ldst_misalign_ma;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb, wbk_data_wb2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ma_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
    .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma),
    .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma), .stall(stall), .rst_pipe(rst_pipe),
    .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr), .dc_be(dc_be),
    .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .dc_stall(dc_stall), .ldst_misalign_ma(ldst_misalign_ma),
    .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .wbk_data_wb(wbk_data_wb), .wbk_data_wb2(wbk_data_wb2)
  );

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int unsigned m_width(input logic [2:0] code);
    if (code[1:0] == 2'b00) return 1;
    if (code[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] code, input logic [31:0] adr);
    if (code[1:0] == 2'b11) return 1'b0;
    return (adr % m_width(code)) != 0;
  endfunction

  function automatic int unsigned m_lane(input logic [2:0] code, input logic [31:0] adr);
    int unsigned w;
    w = m_width(code);
    return ((adr % 4) / w) * w;
  endfunction

  function automatic logic [3:0] m_st_be(input logic [2:0] code, input logic [31:0] adr);
    int unsigned t;
    t = ((1 << m_width(code)) - 1) << m_lane(code, adr);
    return t[3:0];
  endfunction

  function automatic logic [31:0] m_st_wdata(input logic [2:0] code, input logic [31:0] d);
    if (m_width(code) == 1) return (d & 32'hFF) * 32'h01010101;
    if (m_width(code) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] code, input logic [31:0] adr,
                                         input logic [31:0] rdata);
    int unsigned w;
    logic [31:0] v;
    w = m_width(code);
    if (w == 4) return rdata;
    v = (rdata >> (8 * m_lane(code, adr))) & ((32'd1 << (8 * w)) - 1);
    if (!code[2] && v >= (32'd1 << (8 * w - 1))) v = v - (32'd1 << (8 * w));
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_ld_ma = 0; cmd_st_ma = 0; rd_adr_ma = 0; rd_data_ma = 0;
    wbk_rd_reg_ma = 0; st_data_ma = 0; ldst_code_ma = 0;
    stall = 0; rst_pipe = 0; dc_ack = 0; dc_rdata = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    n_tests++;
    if ({dc_req, dc_we, dc_adr, dc_be, dc_wdata, dc_stall, ldst_misalign_ma} !== '0) begin
      n_fail++;
      $display("FAIL reset_req got req=%b we=%b adr=%h be=%b wd=%h st=%b mis=%b want all 0",
               dc_req, dc_we, dc_adr, dc_be, dc_wdata, dc_stall, ldst_misalign_ma);
    end
    n_tests++;
    if ({rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2} !== '0) begin
      n_fail++;
      $display("FAIL reset_wb got adr=%h en=%b d=%h d2=%h want all 0",
               rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sw_hit();
    cmd_st_ma = 1; rd_data_ma = 32'h100; st_data_ma = 32'hDEADBEEF;
    ldst_code_ma = 3'b010; dc_ack = 1;
    #1;
    n_tests++;
    if ({dc_req, dc_we, dc_be, dc_stall} !== {1'b1, 1'b1, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_ctrl got req=%b we=%b be=%b stall=%b want 1 1 1111 0",
               dc_req, dc_we, dc_be, dc_stall);
    end
    n_tests++;
    if ({dc_adr, dc_wdata} !== {30'h40, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL sw_data got adr=%h wd=%h want 40 deadbeef", dc_adr, dc_wdata);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if ({dc_req, dc_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL sw_after got req=%b stall=%b want 0 0", dc_req, dc_stall);
    end
    tick();
  endtask

  task automatic test_sb();
    cmd_st_ma = 1; rd_data_ma = 32'h103; st_data_ma = 32'h000000A5;
    ldst_code_ma = 3'b000; dc_ack = 1;
    #1;
    n_tests++;
    if ({dc_be, dc_wdata} !== {4'b1000, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL sb_fmt got be=%b wd=%h want 1000 a5a5a5a5", dc_be, dc_wdata);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_lb_miss(input logic [2:0] code, input logic [31:0] exp);
    cmd_ld_ma = 1; rd_adr_ma = 5'd7; wbk_rd_reg_ma = 1; rd_data_ma = 32'h102;
    ldst_code_ma = code; dc_rdata = 32'h12F03456;
    for (int k = 0; k < 4; k++) begin
      dc_ack = (k == 3);
      #1;
      n_tests++;
      if (dc_stall !== (k < 3)) begin
        n_fail++;
        $display("FAIL lbmiss_stall c%0d got %b want %b", k, dc_stall, (k < 3));
      end
      n_tests++;
      if ({dc_req, dc_adr, dc_be, dc_we} !== {1'b1, 30'h40, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL lbmiss_req c%0d got req=%b adr=%h be=%b we=%b want 1 40 1111 0",
                 k, dc_req, dc_adr, dc_be, dc_we);
      end
      tick();
    end
    n_tests++;
    if ({wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb} !== {exp, 5'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL lbmiss_wb code=%0d got d=%h adr=%0d en=%b want %h 7 1",
               code, wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb, exp);
    end
    clear_inputs();
    #1;
    n_tests++;
    if ({dc_req, dc_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL lbmiss_idle got req=%b stall=%b want 0 0", dc_req, dc_stall);
    end
    tick();
  endtask

  task automatic test_misalign();
    cmd_ld_ma = 1; ldst_code_ma = 3'b010; rd_data_ma = 32'h101;
    rd_adr_ma = 5'd9; wbk_rd_reg_ma = 1; dc_ack = 1;
    #1;
    n_tests++;
    if ({dc_req, ldst_misalign_ma, dc_stall} !== 3'b010) begin
      n_fail++;
      $display("FAIL mis_lw got req=%b mis=%b stall=%b want 0 1 0",
               dc_req, ldst_misalign_ma, dc_stall);
    end
    tick();
    n_tests++;
    if ({wbk_rd_reg_wb, rd_adr_wb} !== {1'b0, 5'd9}) begin
      n_fail++;
      $display("FAIL mis_wb got en=%b adr=%0d want 0 9", wbk_rd_reg_wb, rd_adr_wb);
    end
    clear_inputs();
    #1;
    n_tests++;
    if (ldst_misalign_ma !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_pulse got %b want 0", ldst_misalign_ma);
    end
    tick();
    // misaligned SH held in MA by an external stall for two extra cycles
    cmd_st_ma = 1; ldst_code_ma = 3'b001; rd_data_ma = 32'h201;
    for (int k = 0; k < 3; k++) begin
      stall = (k < 2);
      #1;
      n_tests++;
      if ({ldst_misalign_ma, dc_req} !== 2'b10) begin
        n_fail++;
        $display("FAIL mis_stalled c%0d got mis=%b req=%b want 1 0", k, ldst_misalign_ma, dc_req);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_drain();
    rd_adr_ma = 5'd3; wbk_rd_reg_ma = 1; rd_data_ma = 32'h33;
    tick();
    cmd_ld_ma = 1; ldst_code_ma = 3'b001; rd_data_ma = 32'h102;
    rd_adr_ma = 5'd4; wbk_rd_reg_ma = 1; dc_rdata = 32'hCAFEF00D;
    #1;
    n_tests++;
    if ({dc_req, dc_stall, wbk_rd_reg_wb} !== 3'b111) begin
      n_fail++;
      $display("FAIL drain_c0 got req=%b stall=%b en=%b want 1 1 1", dc_req, dc_stall, wbk_rd_reg_wb);
    end
    tick();
    rst_pipe = 1;
    #1;
    n_tests++;
    if ({dc_req, dc_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL drain_flush got req=%b stall=%b want 1 1", dc_req, dc_stall);
    end
    tick();
    clear_inputs();
    dc_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      dc_ack = (k == 1);
      #1;
      n_tests++;
      if ({dc_req, dc_stall, dc_adr, dc_be, wbk_rd_reg_wb} !== {1'b1, 1'b1, 30'h40, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL drain_hold c%0d got req=%b stall=%b adr=%h be=%b en=%b want 1 1 40 1111 0",
                 k, dc_req, dc_stall, dc_adr, dc_be, wbk_rd_reg_wb);
      end
      tick();
    end
    dc_ack = 0;
    #1;
    n_tests++;
    if ({dc_req, dc_stall, wbk_rd_reg_wb} !== 3'b000) begin
      n_fail++;
      $display("FAIL drain_done got req=%b stall=%b en=%b want 0 0 0", dc_req, dc_stall, wbk_rd_reg_wb);
    end
    tick();
  endtask

  task automatic test_flush_with_ack();
    cmd_ld_ma = 1; ldst_code_ma = 3'b010; rd_data_ma = 32'h300;
    tick();
    rst_pipe = 1; dc_ack = 1;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if ({dc_req, dc_stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_ack got req=%b stall=%b want 0 0", dc_req, dc_stall);
    end
    tick();
  endtask

  task automatic test_alu_forward();
    rd_adr_ma = 5'd5; rd_data_ma = 32'h55; wbk_rd_reg_ma = 1;
    tick();
    n_tests++;
    if ({wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb} !== {32'h55, 5'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL fwd_ma got d=%h adr=%0d en=%b want 55 5 1", wbk_data_wb, rd_adr_wb, wbk_rd_reg_wb);
    end
    rd_adr_ma = 5'd6; rd_data_ma = 32'h77;
    tick();
    n_tests++;
    if ({wbk_data_wb2, wbk_data_wb} !== {32'h55, 32'h77}) begin
      n_fail++;
      $display("FAIL fwd_wb got d2=%h d=%h want 55 77", wbk_data_wb2, wbk_data_wb);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    cmd_ld_ma = 1; ldst_code_ma = 3'b010; rd_data_ma = 32'h200;
    rd_adr_ma = 5'd2; wbk_rd_reg_ma = 1;
    tick();
    n_tests++;
    if (dc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstwait_req got %b want 1", dc_req);
    end
    rst_n = 0;
    clear_inputs();
    tick();
    n_tests++;
    if ({dc_req, dc_we, dc_adr, dc_be, dc_wdata, dc_stall, ldst_misalign_ma,
         rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2} !== '0) begin
      n_fail++;
      $display("FAIL rstwait_out got req=%b stall=%b adr=%h en=%b d=%h d2=%h want all 0",
               dc_req, dc_stall, dc_adr, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] prev_wb, adr, sdata, rdata, exp_d;
    logic [2:0]  code;
    logic [4:0]  rd;
    logic        ld, st, wen, mis, acc;
    int unsigned kind, lat;
    clear_inputs();
    tick();
    prev_wb = 32'h0;
    for (int i = 0; i < 200; i++) begin
      kind  = $urandom_range(0, 2);
      ld    = (kind == 0);
      st    = (kind == 1);
      code  = 3'($urandom_range(0, 7));
      adr   = $urandom;
      if ($urandom_range(0, 1) == 1) adr = adr & 32'hFFFF_FFFC;
      sdata = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom_range(0, 31));
      wen   = 1'($urandom_range(0, 1));
      lat   = $urandom_range(0, 3);
      mis   = (ld || st) && m_mis(code, adr);
      acc   = (ld || st) && !mis;
      cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code; rd_data_ma = adr;
      st_data_ma = sdata; rd_adr_ma = rd; wbk_rd_reg_ma = wen; dc_rdata = rdata;
      if (acc) begin
        for (int k = 0; k <= int'(lat); k++) begin
          dc_ack = (k == int'(lat));
          #1;
          n_tests++;
          if ({dc_req, dc_stall, dc_we, ldst_misalign_ma} !== {1'b1, (k != int'(lat)), st, 1'b0}) begin
            n_fail++;
            $display("FAIL rnd_ctrl i=%0d c%0d got req=%b stall=%b we=%b mis=%b want 1 %b %b 0",
                     i, k, dc_req, dc_stall, dc_we, ldst_misalign_ma, (k != int'(lat)), st);
          end
          n_tests++;
          if ({dc_adr, dc_be} !== {adr[31:2], (ld ? 4'hF : m_st_be(code, adr))}) begin
            n_fail++;
            $display("FAIL rnd_adr i=%0d got adr=%h be=%b want %h %b",
                     i, dc_adr, dc_be, adr[31:2], (ld ? 4'hF : m_st_be(code, adr)));
          end
          if (st) begin
            n_tests++;
            if (dc_wdata !== m_st_wdata(code, sdata)) begin
              n_fail++;
              $display("FAIL rnd_wdata i=%0d code=%0d got %h want %h",
                       i, code, dc_wdata, m_st_wdata(code, sdata));
            end
          end
          tick();
        end
      end else begin
        dc_ack = 1'($urandom_range(0, 1));
        #1;
        n_tests++;
        if ({dc_req, dc_stall, ldst_misalign_ma} !== {1'b0, 1'b0, mis}) begin
          n_fail++;
          $display("FAIL rnd_noreq i=%0d got req=%b stall=%b mis=%b want 0 0 %b",
                   i, dc_req, dc_stall, ldst_misalign_ma, mis);
        end
        tick();
      end
      exp_d = ld ? m_load(code, adr, rdata) : adr;
      n_tests++;
      if ({rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2} !==
          {rd, (wen && !mis), exp_d, prev_wb}) begin
        n_fail++;
        $display("FAIL rnd_wb i=%0d got adr=%0d en=%b d=%h d2=%h want %0d %b %h %h",
                 i, rd_adr_wb, wbk_rd_reg_wb, wbk_data_wb, wbk_data_wb2,
                 rd, (wen && !mis), exp_d, prev_wb);
      end
      prev_wb = exp_d;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_sw_hit();
    test_sb();
    test_lb_miss(3'b000, 32'hFFFFFFF0);
    test_lb_miss(3'b100, 32'h000000F0);
    test_misalign();
    test_drain();
    test_flush_with_ack();
    test_alu_forward();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
